node_evaluator: RTL and testbench
=================================

NODE_EVALUATOR -- requirements
Module: node_evaluator

Interface
REQ-001 SHALL have parameter COEFF_W, default 24, meaning signed coefficient width, equal to the coefficient memory word width.
REQ-002 SHALL have parameter WORDS, default 5, meaning coefficient words per node: WORDS-1 weights followed by one bias.
REQ-003 SHALL have parameter FEAT_W, default 12, meaning signed feature width.
REQ-004 SHALL have derived parameter ACC_W = COEFF_W+FEAT_W+$clog2(WORDS), meaning signed accumulator/result width.
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all state changes on posedge clk.
REQ-006 SHALL have port reset, input, 1 bit, meaning reset, synchronous, active-high.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning a feature vector is offered.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a feature vector this cycle.
REQ-009 SHALL have port features, input, FEAT_W*(WORDS-1) bits, meaning packed signed features, feature k at bits [FEAT_W*k +: FEAT_W].
REQ-010 SHALL have port mem_ce, output, 1 bit, meaning coefficient memory enable.
REQ-011 SHALL have port mem_we, output, 1 bit, meaning memory write enable, constant 0.
REQ-012 SHALL have port mem_a, output, $clog2(WORDS) bits, meaning coefficient word address.
REQ-013 SHALL have port mem_q, input, COEFF_W bits, meaning registered memory read data, valid one clock edge after mem_a/mem_ce are presented.
REQ-014 SHALL have port out_valid, output, 1 bit, meaning a result is held.
REQ-015 SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-016 SHALL have port out_sum, output, ACC_W bits, meaning signed sum of w[k]*f[k] for k<WORDS-1, plus bias.
REQ-017 SHALL have port out_decision, output, 1 bit, meaning 1 iff out_sum >= 0 (signed).

Function
REQ-018 SHALL implement FSM states IDLE, FETCH, HOLD.
REQ-019 SHALL, in IDLE, drive in_ready=1, mem_ce=0, mem_a=0 and out_valid=0.
REQ-020 SHALL, at the edge with in_valid&&in_ready, latch features, clear the accumulator and enter FETCH; features inputs are ignored thereafter until the next accept.
REQ-021 SHALL, in FETCH, drive mem_ce=1 and present mem_a=k during the k-th cycle after the accept (k=0..WORDS-1), one address per cycle, incrementing without gaps.
REQ-022 SHALL pipeline-align the read data so that mem_q in the cycle after address k is used for word k.
REQ-023 SHALL, for k<WORDS-1, add sign_extend(mem_q)*sign_extend(f[k]) to the accumulator, as a full-precision signed product.
REQ-024 SHALL, for k=WORDS-1, add sign_extend(mem_q) as the bias, with no multiply.
REQ-025 SHALL drive mem_ce=0 after the address WORDS-1 cycle.
REQ-026 SHALL enter HOLD and assert out_valid exactly WORDS+1 edges after the accepting edge, with out_sum/out_decision registered at that edge.
REQ-027 SHALL, in HOLD, keep out_valid, out_sum and out_decision stable until out_valid&&out_ready, with in_ready=0.
REQ-028 SHALL, on the output handshake edge, clear out_valid and return to IDLE; in_ready=1 in the following cycle.
REQ-029 SHALL NOT overflow: the ACC_W sizing covers WORDS-1 extreme products plus bias, and no saturation logic is required.
REQ-030 SHALL hold mem_we=0 in every state, including reset.

Reset
REQ-031 SHALL, while reset=1 at an edge, go to IDLE with out_valid=0, out_sum=0, out_decision=0, mem_ce=0, mem_a=0 and accumulator=0, regardless of state.
REQ-032 SHALL, on reset mid-FETCH or mid-HOLD, discard the computation; no out_valid for it ever asserts.
REQ-033 SHALL have in_ready=1 in the first cycle with reset=0.

Verification
REQ-034 SHALL cover: memory {3,-2,1,0,bias -5} with features {4,1,2,7} -> out_valid at edge 6 after accept, out_sum=7, out_decision=1, mem_a sequence 0,1,2,3,4 with mem_ce high exactly 5 cycles.
REQ-035 SHALL cover: same memory with features all 0 -> out_sum=-5, out_decision=0.
REQ-036 SHALL cover: all weights -2^23, features all -2^11, bias 2^23-1 -> out_sum=4*2^34+2^23-1 exact, decision=1.
REQ-037 SHALL cover: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, mem_ce=0; out_ready=1 -> out_valid=0 and in_ready=1 next cycle.
REQ-038 SHALL cover: reset pulsed 3 cycles after accept -> mem_ce=0 and out_valid=0 after the reset edge, in_ready=1 in the first non-reset cycle, and a new vector computes correctly.
REQ-039 SHALL cover: features changed every cycle during FETCH -> result equals that of the vector latched at accept.

Source files
------------

// File: rtl/node_evaluator.sv
// node_evaluator: multiplies a latched feature vector by WORDS-1 coefficients
// streamed from a registered memory, adds a bias word, and holds the signed result.
`default_nettype none

module node_evaluator #(
  parameter int COEFF_W = 24,
  parameter int WORDS   = 5,
  parameter int FEAT_W  = 12,
  parameter int ACC_W   = COEFF_W + FEAT_W + $clog2(WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_W*(WORDS-1)-1:0]   features,
  output logic                          mem_ce,
  output logic                          mem_we,
  output logic [$clog2(WORDS)-1:0]      mem_a,
  input  logic [COEFF_W-1:0]            mem_q,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_W-1:0]              out_sum,
  output logic                          out_decision
);

  localparam int AW     = $clog2(WORDS);
  localparam int NF     = WORDS - 1;
  localparam int PROD_W = COEFF_W + FEAT_W;
  localparam int PAD_W  = FEAT_W * (1 << AW);
  localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                    state;
  logic [FEAT_W*NF-1:0]      feat_q;
  logic signed [ACC_W-1:0]   acc;
  logic                      data_vld;
  logic [AW-1:0]             data_k;

  logic [PAD_W-1:0]          feat_pad;
  logic signed [FEAT_W-1:0]  feat_sel;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   acc_next;

  assign mem_we = 1'b0;

  // Padding to a power-of-two count keeps the variable slice in range for the bias index.
  assign feat_pad = PAD_W'(feat_q);
  assign feat_sel = feat_pad[FEAT_W*data_k +: FEAT_W];
  assign prod     = $signed(mem_q) * feat_sel;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bias_ext = {{(ACC_W-COEFF_W){mem_q[COEFF_W-1]}}, mem_q};
  assign acc_next = acc + ((data_k == LAST) ? bias_ext : prod_ext);

  // data_vld/data_k trail mem_ce/mem_a by one edge, matching the memory read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      mem_ce       <= 1'b0;
      mem_a        <= '0;
      data_vld     <= 1'b0;
      data_k       <= '0;
      acc          <= '0;
      feat_q       <= '0;
      out_valid    <= 1'b0;
      out_sum      <= '0;
      out_decision <= 1'b0;
    end else begin
      data_vld <= mem_ce;
      data_k   <= mem_a;
      case (state)
        IDLE: begin
          if (in_valid) begin
            feat_q   <= features;
            acc      <= '0;
            mem_ce   <= 1'b1;
            mem_a    <= '0;
            in_ready <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ce) begin
            if (mem_a == LAST) begin
              mem_ce <= 1'b0;
              mem_a  <= '0;
            end else begin
              mem_a <= mem_a + 1'b1;
            end
          end
          if (data_vld) begin
            acc <= acc_next;
            if (data_k == LAST) begin
              out_sum      <= acc_next;
              out_decision <= ~acc_next[ACC_W-1];
              out_valid    <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_node_evaluator.sv
// ============================================================================
// Module      : tb_node_evaluator
// Description : Self-checking bench for node_evaluator: directed corner cases
//               plus random vectors compared against an arithmetic model.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_node_evaluator;

    localparam int COEFF_W = 24;
    localparam int WORDS   = 5;
    localparam int FEAT_W  = 12;
    localparam int ACC_W   = COEFF_W + FEAT_W + $clog2(WORDS);
    localparam int AW      = $clog2(WORDS);
    localparam int NF      = WORDS - 1;

    logic                     clk;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic [FEAT_W*NF-1:0]     features;
    logic                     mem_ce;
    logic                     mem_we;
    logic [AW-1:0]            mem_a;
    logic [COEFF_W-1:0]       mem_q;
    logic                     out_valid;
    logic                     out_ready;
    logic [ACC_W-1:0]         out_sum;
    logic                     out_decision;

    int checks = 0;
    int errors = 0;

    longint wt [NF];
    longint ft [NF];
    longint bias;
    logic [COEFF_W-1:0] mem [8];

    node_evaluator #(.COEFF_W(COEFF_W), .WORDS(WORDS), .FEAT_W(FEAT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .features(features), .mem_ce(mem_ce), .mem_we(mem_we), .mem_a(mem_a),
        .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_decision(out_decision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ce) mem_q <= mem[mem_a];
    end

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic longint rand_signed(input int w);
        longint v;
        v = longint'($urandom) & ((64'sd1 <<< w) - 1);
        if (v >= (64'sd1 <<< (w - 1))) v = v - (64'sd1 <<< w);
        return v;
    endfunction

    task automatic run_vec(input string tag, input bit scramble, input int hold_cycles);
        longint exp_sum;
        int lat, ce_cnt;
        bit addr_ok, we_ok, stable_ok;
        logic [ACC_W-1:0] held;
        exp_sum = bias;
        for (int k = 0; k < NF; k++) exp_sum += wt[k] * ft[k];
        for (int k = 0; k < NF; k++) mem[k] = COEFF_W'(wt[k]);
        mem[NF] = COEFF_W'(bias);
        for (int k = 0; k < NF; k++) features[FEAT_W*k +: FEAT_W] = FEAT_W'(ft[k]);
        check({tag, ".ready_before"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0; ce_cnt = 0; addr_ok = 1'b1; we_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (mem_ce) begin
                if (int'(mem_a) != ce_cnt) addr_ok = 1'b0;
                ce_cnt++;
            end
            if (mem_we !== 1'b0) we_ok = 1'b0;
            if (scramble) features = {$urandom, $urandom};
            step();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(WORDS + 1));
        check({tag, ".ce_cycles"}, 64'(ce_cnt), 64'(WORDS));
        check({tag, ".addr_seq"}, 64'(addr_ok), 64'd1);
        check({tag, ".we_low"}, 64'(we_ok), 64'd1);
        check({tag, ".sum"}, 64'($signed(out_sum)), exp_sum);
        check({tag, ".decision"}, 64'(out_decision), (exp_sum >= 0) ? 64'd1 : 64'd0);
        check({tag, ".ready_busy"}, 64'(in_ready), 64'd0);
        held = out_sum;
        stable_ok = 1'b1;
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            if (out_valid !== 1'b1 || out_sum !== held || in_ready !== 1'b0 || mem_ce !== 1'b0)
                stable_ok = 1'b0;
        end
        if (hold_cycles > 0) check({tag, ".hold_stable"}, 64'(stable_ok), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ".valid_cleared"}, 64'(out_valid), 64'd0);
        check({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        bit never_valid;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; features = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) step();
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.out_sum", 64'(out_sum), 64'd0);
        check("reset.decision", 64'(out_decision), 64'd0);
        check("reset.mem_ce", 64'(mem_ce), 64'd0);
        check("reset.mem_a", 64'(mem_a), 64'd0);
        check("reset.mem_we", 64'(mem_we), 64'd0);
        reset = 1'b0;
        check("reset.first_ready", 64'(in_ready), 64'd1);

        wt = '{3, -2, 1, 0}; bias = -5; ft = '{4, 1, 2, 7};
        run_vec("basic", 1'b0, 0);
        ft = '{0, 0, 0, 0};
        run_vec("zero_feat", 1'b0, 0);

        wt = '{-(64'sd1 <<< 23), -(64'sd1 <<< 23), -(64'sd1 <<< 23), -(64'sd1 <<< 23)};
        ft = '{-2048, -2048, -2048, -2048};
        bias = (64'sd1 <<< 23) - 1;
        run_vec("extreme", 1'b0, 0);
        check("extreme.const", 64'($signed(out_sum)), (64'sd1 <<< 36) + (64'sd1 <<< 23) - 64'sd1);

        wt = '{3, -2, 1, 0}; bias = -5; ft = '{4, 1, 2, 7};
        run_vec("hold", 1'b0, 10);
        run_vec("scramble", 1'b1, 2);

        for (int k = 0; k < NF; k++) features[FEAT_W*k +: FEAT_W] = 12'd100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset.mem_ce", 64'(mem_ce), 64'd0);
        check("midreset.out_valid", 64'(out_valid), 64'd0);
        check("midreset.in_ready", 64'(in_ready), 64'd1);
        never_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0 || mem_ce !== 1'b0) never_valid = 1'b0;
        end
        check("midreset.discarded", 64'(never_valid), 64'd1);
        wt = '{5, 6, -7, 8}; bias = 11; ft = '{-1, 2, 3, -4};
        run_vec("after_reset", 1'b0, 0);

        for (int n = 0; n < 20; n++) begin
            for (int k = 0; k < NF; k++) begin
                wt[k] = rand_signed(COEFF_W);
                ft[k] = rand_signed(FEAT_W);
            end
            bias = rand_signed(COEFF_W);
            run_vec($sformatf("rand%0d", n), n[0], int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, observed running expected finished");
        $finish;
    end

endmodule

`default_nettype wire
